// File: rtl/bht_access_scheduler_pkg.sv
// Shared types and default sizing for the BHT access scheduler.
package bht_access_scheduler_pkg;

   // Default BHT index width (2^DEF_LOWER entries).
   localparam int DEF_LOWER      = 5;
   // Default depth of the pending-update queue (power of two, >= 2).
   localparam int DEF_QDEPTH     = 4;
   // Default limit on consecutive lookup grants while updates wait.
   localparam int DEF_STARVE_MAX = 3;

   // CLEAR walks every entry to strongly-not-taken; RUN arbitrates the port.
   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

endpackage

// File: rtl/bht_access_scheduler_if.sv
// Fetch/resolve/BHT-port bundle between the scheduler and its neighbours.
interface bht_access_scheduler_if #(
   parameter int LOWER = bht_access_scheduler_pkg::DEF_LOWER
);
   logic             flush_req;
   logic             lookup_valid;
   logic [LOWER-1:0] lookup_addr;
   logic             lookup_ready;
   logic             update_valid;
   logic [LOWER-1:0] update_addr;
   logic             update_taken;
   logic             update_ready;
   logic             bht_en;
   logic             bht_we;
   logic [LOWER-1:0] bht_addr;
   logic             bht_taken;
   logic             bht_clr;
   logic             pred_valid;
   logic             busy;

   // Client side: fetch, branch resolution and the BHT array.
   modport master (
      output flush_req, lookup_valid, lookup_addr,
             update_valid, update_addr, update_taken,
      input  lookup_ready, update_ready, bht_en, bht_we, bht_addr,
             bht_taken, bht_clr, pred_valid, busy
   );

   // Scheduler side.
   modport slave (
      input  flush_req, lookup_valid, lookup_addr,
             update_valid, update_addr, update_taken,
      output lookup_ready, update_ready, bht_en, bht_we, bht_addr,
             bht_taken, bht_clr, pred_valid, busy
   );
endinterface

// File: rtl/bht_update_fifo.sv
// Pending-update queue; each entry is {addr, taken}. Head is always visible.
module bht_update_fifo
   import bht_access_scheduler_pkg::*;
#(
   parameter int LOWER  = DEF_LOWER,
   parameter int QDEPTH = DEF_QDEPTH
) (
   input  logic           clk,
   input  logic           arst_n,
   input  logic           flush_i,
   input  logic           push_i,
   input  logic [LOWER:0] entry_i,
   input  logic           pop_i,
   output logic [LOWER:0] head_o,
   output logic           empty_o,
   output logic           full_o
);
   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;

   logic [LOWER:0]  mem_q [QDEPTH];
   logic [PW-1:0]   wr_ptr_q;
   logic [PW-1:0]   rd_ptr_q;
   logic [CW-1:0]   count_q;
   logic            do_push;
   logic            do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(QDEPTH));
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign head_o  = mem_q[rd_ptr_q];

   // Pointers wrap naturally at QDEPTH; flush discards every pending entry.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry storage.
   // NOTE: the storage array has no reset; the count decides which slots
   // are meaningful, and leaving it unreset lets it map onto plain RAM/flops.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= entry_i;
   end

endmodule

// File: rtl/bht_access_scheduler.sv
// Single-port BHT arbiter: clear walk, then lookup-vs-update scheduling with
// a starvation limit so queued updates are eventually written.
module bht_access_scheduler
   import bht_access_scheduler_pkg::*;
#(
   parameter int LOWER      = DEF_LOWER,
   parameter int QDEPTH     = DEF_QDEPTH,
   parameter int STARVE_MAX = DEF_STARVE_MAX
) (
   input logic                   clk,
   input logic                   arst_n,
   bht_access_scheduler_if.slave bus
);
   localparam int             SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0]  STARVE_LIM = SW'(STARVE_MAX);

   state_e           state_q;
   logic [LOWER-1:0] walk_q;
   logic [SW-1:0]    starve_q;
   logic             pred_q;

   logic             in_run;
   logic             q_empty;
   logic             q_full;
   logic             force_upd;
   logic             grant_lookup;
   logic             grant_update;
   logic             push;
   logic [LOWER:0]   head;

   assign in_run       = (state_q == ST_RUN);
   assign force_upd    = !q_empty && (starve_q == STARVE_LIM);
   assign grant_lookup = in_run && bus.lookup_valid && !force_upd;
   assign grant_update = in_run && !q_empty && !grant_lookup;
   // An update offered alongside a flush would be discarded anyway, so drop it.
   assign push         = bus.update_valid && bus.update_ready && !bus.flush_req;

   assign bus.lookup_ready = grant_lookup;
   assign bus.update_ready = in_run && !q_full;
   assign bus.busy         = !in_run;
   assign bus.pred_valid   = pred_q;

   bht_update_fifo #(
      .LOWER  (LOWER),
      .QDEPTH (QDEPTH)
   ) u_fifo (
      .clk     (clk),
      .arst_n  (arst_n),
      .flush_i (bus.flush_req),
      .push_i  (push),
      .entry_i ({bus.update_addr, bus.update_taken}),
      .pop_i   (grant_update),
      .head_o  (head),
      .empty_o (q_empty),
      .full_o  (q_full)
   );

   // Shared BHT port: clear writes during the walk, else the granted access.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      bus.bht_en    = 1'b0;
      bus.bht_we    = 1'b0;
      bus.bht_clr   = 1'b0;
      bus.bht_taken = 1'b0;
      bus.bht_addr  = walk_q;
      if (!in_run) begin
         // Held off while reset is asserted so the array sees no writes then.
         bus.bht_en  = arst_n;
         bus.bht_we  = arst_n;
         bus.bht_clr = arst_n;
      end else if (grant_lookup) begin
         bus.bht_en   = 1'b1;
         bus.bht_addr = bus.lookup_addr;
      end else if (grant_update) begin
         bus.bht_en    = 1'b1;
         bus.bht_we    = 1'b1;
         bus.bht_addr  = head[LOWER:1];
         bus.bht_taken = head[0];
      end
   end

   // Mode FSM with clear walk, starvation counter and prediction-valid pipe.
   always_ff @(posedge clk or negedge arst_n) begin
      // NOTE: state uses non-blocking assignments so every register samples
      // the pre-edge values, independent of statement order.
      if (!arst_n) begin
         state_q  <= ST_CLEAR;
         walk_q   <= '0;
         starve_q <= '0;
         pred_q   <= 1'b0;
      end else begin
         // A lookup granted in the flush cycle completes, but the BHT is
         // being cleared, so its prediction is not reported.
         pred_q <= grant_lookup && !bus.flush_req;
         case (state_q)
            ST_CLEAR: begin
               starve_q <= '0;
               if (bus.flush_req) begin
                  walk_q <= '0;
               end else if (walk_q == '1) begin
                  walk_q  <= '0;
                  state_q <= ST_RUN;
               end else begin
                  walk_q <= walk_q + LOWER'(1);
               end
            end
            ST_RUN: begin
               if (bus.flush_req) begin
                  state_q  <= ST_CLEAR;
                  walk_q   <= '0;
                  starve_q <= '0;
               end else if (grant_update) begin
                  starve_q <= '0;
               end else if (grant_lookup && !q_empty && (starve_q != STARVE_LIM)) begin
                  starve_q <= starve_q + SW'(1);
               end
            end
            default: state_q <= ST_CLEAR;
         endcase
      end
   end

endmodule

// File: tb/tb_bht_access_scheduler.sv
// Directed bench for bht_access_scheduler: vector table plus corner sequences.
module tb_bht_access_scheduler;

   localparam logic [7:0] C_LR   = 8'h80;  // lookup_ready
   localparam logic [7:0] C_UR   = 8'h40;  // update_ready
   localparam logic [7:0] C_EN   = 8'h20;  // bht_en
   localparam logic [7:0] C_WE   = 8'h10;  // bht_we
   localparam logic [7:0] C_CLR  = 8'h08;  // bht_clr
   localparam logic [7:0] C_TK   = 8'h04;  // bht_taken
   localparam logic [7:0] C_PV   = 8'h02;  // pred_valid
   localparam logic [7:0] C_BUSY = 8'h01;  // busy
   localparam logic [7:0] C_WALK = C_EN | C_WE | C_CLR | C_BUSY;

   typedef struct {
      logic       lv;
      logic [4:0] la;
      logic       uv;
      logic [4:0] ua;
      logic       ut;
      logic [7:0] exp;
      logic [4:0] ea;
   } vec_t;

   logic clk;
   logic arst_n;
   int   checks = 0;
   int   errors = 0;

   bht_access_scheduler_if bus ();

   bht_access_scheduler dut (
      .clk    (clk),
      .arst_n (arst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string name, input logic [7:0] exp, input logic [4:0] ea);
      logic [7:0] act;
      act = {bus.lookup_ready, bus.update_ready, bus.bht_en, bus.bht_we,
             bus.bht_clr, bus.bht_taken, bus.pred_valid, bus.busy};
      check({name, ".ctrl"}, act, exp);
      if ((exp & C_EN) != 8'h00) check({name, ".addr"}, bus.bht_addr, ea);
   endtask

   task automatic drive(input logic lv, input logic [4:0] la, input logic uv,
                        input logic [4:0] ua, input logic ut, input logic fl);
      bus.lookup_valid = lv;
      bus.lookup_addr  = la;
      bus.update_valid = uv;
      bus.update_addr  = ua;
      bus.update_taken = ut;
      bus.flush_req    = fl;
   endtask

   // Sample mid-cycle, then advance to just after the next rising edge.
   task automatic step(input string name, input logic [7:0] exp, input logic [4:0] ea);
      @(negedge clk);
      check_outs(name, exp, ea);
      @(posedge clk);
      #1;
   endtask

   task automatic run_walk(input string name, input int n);
      for (int i = 0; i < n; i++) begin
         step($sformatf("%s[%0d]", name, i), C_WALK, 5'(i));
      end
   endtask

   vec_t vecs [12];

   initial begin
      //             lv la  uv ua  ut  expected                          addr
      vecs[0]  = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, C_UR,                              5'd0};
      vecs[1]  = '{1'b1, 5'd7, 1'b0, 5'd0, 1'b0, C_LR | C_UR | C_EN,                5'd7};
      vecs[2]  = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, C_UR | C_PV,                       5'd0};
      vecs[3]  = '{1'b1, 5'd1, 1'b1, 5'd3, 1'b1, C_LR | C_UR | C_EN,                5'd1};
      vecs[4]  = '{1'b1, 5'd2, 1'b0, 5'd0, 1'b0, C_LR | C_UR | C_EN | C_PV,         5'd2};
      vecs[5]  = '{1'b1, 5'd4, 1'b0, 5'd0, 1'b0, C_LR | C_UR | C_EN | C_PV,         5'd4};
      vecs[6]  = '{1'b1, 5'd5, 1'b0, 5'd0, 1'b0, C_LR | C_UR | C_EN | C_PV,         5'd5};
      vecs[7]  = '{1'b1, 5'd6, 1'b0, 5'd0, 1'b0, C_UR | C_EN | C_WE | C_TK | C_PV,  5'd3};
      vecs[8]  = '{1'b1, 5'd6, 1'b0, 5'd0, 1'b0, C_LR | C_UR | C_EN,                5'd6};
      vecs[9]  = '{1'b0, 5'd0, 1'b1, 5'd9, 1'b0, C_UR | C_PV,                       5'd0};
      vecs[10] = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, C_UR | C_EN | C_WE,                5'd9};
      vecs[11] = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, C_UR,                              5'd0};

      arst_n = 1'b0;
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);

      // Reset state, then the initial 32-entry clear walk.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_outs("reset", C_BUSY, 5'd0);
      check("reset.addr", bus.bht_addr, 32'd0);
      @(posedge clk);
      #1;
      arst_n = 1'b1;
      run_walk("walk0", 32);

      // Table: lookup, prediction latency, starvation limit, no-bypass push.
      for (int v = 0; v < 12; v++) begin
         drive(vecs[v].lv, vecs[v].la, vecs[v].uv, vecs[v].ua, vecs[v].ut, 1'b0);
         step($sformatf("vec%0d", v), vecs[v].exp, vecs[v].ea);
      end

      // Five pushes with lookups held: queue fills at four, fifth waits for a pop.
      for (int i = 0; i < 6; i++) begin
         logic [7:0] e;
         int         ua;
         ua = (i < 4) ? 10 + i : 14;
         drive(1'b1, 5'(i), 1'b1, 5'(ua), 1'(ua % 2), 1'b0);
         if (i == 4)      e = C_EN | C_WE | C_PV;
         else if (i == 0) e = C_LR | C_UR | C_EN;
         else if (i == 5) e = C_LR | C_UR | C_EN;
         else             e = C_LR | C_UR | C_EN | C_PV;
         step($sformatf("fill%0d", i), e, (i == 4) ? 5'd10 : 5'(i));
      end
      for (int j = 0; j < 4; j++) begin
         logic [7:0] e;
         drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
         e = C_EN | C_WE;
         if (j > 0)            e = e | C_UR;
         if (j == 0)           e = e | C_PV;
         if (((11 + j) % 2) == 1) e = e | C_TK;
         step($sformatf("drain%0d", j), e, 5'(11 + j));
      end
      step("drained", C_UR, 5'd0);

      // Flush with two queued entries; flush-cycle lookup completes, update dropped.
      drive(1'b1, 5'd1, 1'b1, 5'd20, 1'b1, 1'b0);
      step("fl_q0", C_LR | C_UR | C_EN, 5'd1);
      drive(1'b1, 5'd2, 1'b1, 5'd21, 1'b1, 1'b0);
      step("fl_q1", C_LR | C_UR | C_EN | C_PV, 5'd2);
      drive(1'b1, 5'd3, 1'b1, 5'd22, 1'b1, 1'b1);
      step("fl_go", C_LR | C_UR | C_EN | C_PV, 5'd3);
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      run_walk("walk1", 32);
      for (int k = 0; k < 3; k++) step($sformatf("post_flush%0d", k), C_UR, 5'd0);

      // Flush during the walk restarts it at entry 0.
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
      step("fl_run", C_UR, 5'd0);
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      run_walk("walk2a", 5);
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
      step("walk2_fl", C_WALK, 5'd5);
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      run_walk("walk2b", 32);
      step("walk2_done", C_UR, 5'd0);

      // Asynchronous reset at walk entry 10, then a full walk from 0.
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
      step("fl_rst", C_UR, 5'd0);
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      run_walk("walk3a", 10);
      #2;
      check_outs("pre_rst", C_WALK, 5'd10);
      arst_n = 1'b0;
      #1;
      check_outs("mid_rst", C_BUSY, 5'd0);
      check("mid_rst.addr", bus.bht_addr, 32'd0);
      @(posedge clk);
      #1;
      arst_n = 1'b1;
      run_walk("walk3b", 32);
      step("walk3_done", C_UR, 5'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
